// File: rtl/rv_core_ibex_sim_sram_pkg.sv
// Shared types for the simulation SRAM splitter: TL-UL channel structs,
// opcodes, steering/target enums and the outstanding-counter width helper.
package rv_core_ibex_sim_sram_pkg;

    localparam logic [2:0] OpPutFull       = 3'h0;
    localparam logic [2:0] OpPutPartial    = 3'h1;
    localparam logic [2:0] OpGet           = 3'h4;
    localparam logic [2:0] OpAccessAck     = 3'h0;
    localparam logic [2:0] OpAccessAckData = 3'h1;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic [6:0]  a_user;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic [6:0]  d_user;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

    typedef enum logic [1:0] {StIdle, StXbar, StSram} state_e;
    typedef enum logic {TgtXbar, TgtSram} target_e;

    function automatic int sram_cnt_w(input int max_out);
        return $clog2(max_out + 1);
    endfunction

endpackage

// File: rtl/rv_core_ibex_sim_sram_mem.sv
// Single-port byte-enabled word memory with a registered read port.
module rv_core_ibex_sim_sram_mem #(
    parameter int  Depth = 16384,
    localparam int AW    = $clog2(Depth)
) (
    input  logic          clk_i,
    input  logic          i_req,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [3:0]    i_be,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    // One byte-wide array per lane keeps each lane a plain inferred RAM.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] r_mem [Depth];
            logic [7:0] r_rdata;

            always_ff @(posedge clk_i) begin
                if (i_req) begin
                    if (i_we) begin
                        if (i_be[gi]) begin
                            r_mem[i_addr] <= i_wdata[gi*8 +: 8];
                        end
                    end else begin
                        r_rdata <= r_mem[i_addr];
                    end
                end
            end

            assign o_rdata[gi*8 +: 8] = r_rdata;
        end
    endgenerate

endmodule

// File: rtl/rv_core_ibex_sim_sram.sv
// Data-bus splitter: window hits go to a local SRAM, the rest to the crossbar.
// Optional access counters are enabled by RV_CORE_IBEX_SIM_SRAM_STATS_EN.
module rv_core_ibex_sim_sram
    import rv_core_ibex_sim_sram_pkg::*;
#(
    parameter logic [31:0] SramBase       = 32'h0010_0000,
    parameter logic [31:0] SramMask       = 32'hFFFF_0000,
    parameter int          Depth          = 16384,
    parameter int          MaxOutstanding = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  tl_h2d_t     tl_h_i,
    output tl_d2h_t     tl_h_o,
    output tl_h2d_t     tl_d_o,
    input  tl_d2h_t     tl_d_i,
    output logic [31:0] sram_rd_cnt_o,
    output logic [31:0] sram_wr_cnt_o
);

    localparam int AW   = $clog2(Depth);
    localparam int CntW = sram_cnt_w(MaxOutstanding);

    state_e          r_state, w_state_next;
    logic [CntW-1:0] r_cnt, w_cnt_next;
    logic            r_rsp_valid, r_rsp_error;
    logic [2:0]      r_rsp_opcode;
    logic [1:0]      r_rsp_size;
    logic [7:0]      r_rsp_source;

    target_e     w_tgt;
    state_e      w_tgt_state;
    logic        w_allow, w_sram_free, w_a_ready, w_accept, w_sram_acc;
    logic        w_h_d_valid, w_retire;
    logic        w_op_ok, w_size_ok, w_align_ok, w_range_ok, w_err;
    logic        w_mem_req, w_mem_we;
    logic [31:0] w_word_full, w_mem_rdata;

    assign w_tgt       = ((tl_h_i.a_address & SramMask) == SramBase) ? TgtSram : TgtXbar;
    assign w_tgt_state = (w_tgt == TgtSram) ? StSram : StXbar;
    // Only one target may hold outstanding requests, so responses stay ordered.
    assign w_allow     = (r_cnt == '0) ||
                         ((r_state == w_tgt_state) && (r_cnt < CntW'(MaxOutstanding)));
    assign w_sram_free = !r_rsp_valid || tl_h_i.d_ready;
    assign w_a_ready   = w_allow && ((w_tgt == TgtXbar) ? tl_d_i.a_ready : w_sram_free);
    assign w_accept    = tl_h_i.a_valid && w_a_ready;
    assign w_sram_acc  = w_accept && (w_tgt == TgtSram);

    assign w_h_d_valid = (r_state == StXbar) ? tl_d_i.d_valid : r_rsp_valid;
    assign w_retire    = w_h_d_valid && tl_h_i.d_ready && (r_cnt != '0);

    // Range is judged on the full in-window offset, not the truncated RAM index.
    assign w_word_full = (tl_h_i.a_address & ~SramMask) >> 2;
    assign w_range_ok  = w_word_full < 32'(Depth);
    assign w_op_ok     = (tl_h_i.a_opcode == OpGet) || (tl_h_i.a_opcode == OpPutFull) ||
                         (tl_h_i.a_opcode == OpPutPartial);
    assign w_size_ok   = tl_h_i.a_size <= 2'd2;

    always_comb begin
        w_align_ok = 1'b1;
        case (tl_h_i.a_size)
            2'd1:    w_align_ok = !tl_h_i.a_address[0];
            2'd2:    w_align_ok = (tl_h_i.a_address[1:0] == 2'b00);
            default: w_align_ok = 1'b1;
        endcase
    end

    assign w_err     = !(w_op_ok && w_size_ok && w_align_ok && w_range_ok);
    assign w_mem_req = w_sram_acc && !w_err;
    assign w_mem_we  = tl_h_i.a_opcode != OpGet;

    rv_core_ibex_sim_sram_mem #(.Depth(Depth)) u_mem (
        .clk_i   (clk_i),
        .i_req   (w_mem_req),
        .i_we    (w_mem_we),
        .i_addr  (tl_h_i.a_address[2 +: AW]),
        .i_be    (tl_h_i.a_mask),
        .i_wdata (tl_h_i.a_data),
        .o_rdata (w_mem_rdata)
    );

    always_comb begin
        tl_d_o         = tl_h_i;
        tl_d_o.a_valid = tl_h_i.a_valid && (w_tgt == TgtXbar) && w_allow;
        tl_d_o.d_ready = (r_state == StXbar) ? tl_h_i.d_ready : 1'b1;
    end

    always_comb begin
        tl_h_o = '0;
        if (r_state == StXbar) begin
            tl_h_o = tl_d_i;
        end else if (r_rsp_valid) begin
            tl_h_o.d_valid  = 1'b1;
            tl_h_o.d_opcode = r_rsp_opcode;
            tl_h_o.d_size   = r_rsp_size;
            tl_h_o.d_source = r_rsp_source;
            tl_h_o.d_error  = r_rsp_error;
            tl_h_o.d_data   = (r_rsp_opcode == OpAccessAckData && !r_rsp_error) ?
                              w_mem_rdata : '0;
        end
        tl_h_o.a_ready = w_a_ready;
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        if (w_accept && r_cnt == '0) begin
            w_state_next = w_tgt_state;
        end else if (r_cnt == '0) begin
            w_state_next = StIdle;
        end
        if (w_accept && !w_retire) begin
            w_cnt_next = r_cnt + CntW'(1);
        end else if (!w_accept && w_retire) begin
            w_cnt_next = r_cnt - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= StIdle;
            r_cnt        <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_error  <= 1'b0;
            r_rsp_opcode <= '0;
            r_rsp_size   <= '0;
            r_rsp_source <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_sram_acc) begin
                r_rsp_valid  <= 1'b1;
                r_rsp_error  <= w_err;
                r_rsp_opcode <= (tl_h_i.a_opcode == OpGet) ? OpAccessAckData : OpAccessAck;
                r_rsp_size   <= tl_h_i.a_size;
                r_rsp_source <= tl_h_i.a_source;
            end else if (r_rsp_valid && tl_h_i.d_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

`ifdef RV_CORE_IBEX_SIM_SRAM_STATS_EN
    logic [31:0] r_rd_cnt, r_wr_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
        end else if (w_sram_acc) begin
            if (tl_h_i.a_opcode == OpGet && r_rd_cnt != '1) begin
                r_rd_cnt <= r_rd_cnt + 32'd1;
            end
            if ((tl_h_i.a_opcode == OpPutFull || tl_h_i.a_opcode == OpPutPartial) &&
                r_wr_cnt != '1) begin
                r_wr_cnt <= r_wr_cnt + 32'd1;
            end
        end
    end

    assign sram_rd_cnt_o = r_rd_cnt;
    assign sram_wr_cnt_o = r_wr_cnt;
`else
    assign sram_rd_cnt_o = '0;
    assign sram_wr_cnt_o = '0;
`endif

endmodule

// File: tb/tb_rv_core_ibex_sim_sram.sv
// Directed bench for the simulation SRAM splitter: SRAM path, crossbar path,
// target switching, error responses and mid-operation reset.
module tb_rv_core_ibex_sim_sram;
    import rv_core_ibex_sim_sram_pkg::*;

`ifdef RV_CORE_IBEX_SIM_SRAM_STATS_EN
    localparam bit StatsEn = 1'b1;
`else
    localparam bit StatsEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    tl_h2d_t     h_req, d_req;
    tl_d2h_t     h_rsp, d_rsp;
    logic [31:0] rd_cnt, wr_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int exp_rd   = 0;
    int exp_wr   = 0;

    always #5 clk = ~clk;

    rv_core_ibex_sim_sram #(
        .SramBase       (32'h0010_0000),
        .SramMask       (32'hFFFE_0000),
        .Depth          (16384),
        .MaxOutstanding (2)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .tl_h_i        (h_req),
        .tl_h_o        (h_rsp),
        .tl_d_o        (d_req),
        .tl_d_i        (d_rsp),
        .sram_rd_cnt_o (rd_cnt),
        .sram_wr_cnt_o (wr_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic sram_txn(input string tag, input logic [2:0] op, input logic [31:0] addr,
                            input logic [1:0] size, input logic [3:0] mask,
                            input logic [31:0] data, input logic [31:0] exp_data,
                            input logic exp_err);
        int n;
        logic [7:0] src;
        n   = 0;
        src = 8'(n_checks);
        @(posedge clk); #1;
        h_req.a_valid   = 1'b1;
        h_req.a_opcode  = op;
        h_req.a_size    = size;
        h_req.a_address = addr;
        h_req.a_mask    = mask;
        h_req.a_data    = data;
        h_req.a_source  = src;
        @(negedge clk);
        while (!h_rsp.a_ready && n < 16) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_ready"}, 32'(h_rsp.a_ready), 32'd1);
        @(posedge clk); #1;
        h_req.a_valid = 1'b0;
        if (op == OpGet) exp_rd++;
        else if (op == OpPutFull || op == OpPutPartial) exp_wr++;
        @(negedge clk);
        check_eq({tag, "_dvalid"}, 32'(h_rsp.d_valid), 32'd1);
        check_eq({tag, "_src"}, 32'(h_rsp.d_source), 32'(src));
        check_eq({tag, "_size"}, 32'(h_rsp.d_size), 32'(size));
        check_eq({tag, "_op"}, 32'(h_rsp.d_opcode),
                 32'((op == OpGet) ? OpAccessAckData : OpAccessAck));
        check_eq({tag, "_err"}, 32'(h_rsp.d_error), 32'(exp_err));
        if (op == OpGet || exp_err) begin
            check_eq({tag, "_data"}, h_rsp.d_data, exp_data);
        end
        $display("SRAM %s op=%0d addr=0x%08h size=%0d d_data=0x%08h d_error=%0d",
                 tag, op, addr, size, h_rsp.d_data, h_rsp.d_error);
    endtask

    task automatic xbar_req(input logic [31:0] addr, input logic [7:0] src);
        int n;
        n = 0;
        @(posedge clk); #1;
        h_req.a_valid   = 1'b1;
        h_req.a_opcode  = OpGet;
        h_req.a_size    = 2'd2;
        h_req.a_mask    = 4'hF;
        h_req.a_address = addr;
        h_req.a_source  = src;
        @(negedge clk);
        while (!h_rsp.a_ready && n < 16) begin
            @(negedge clk);
            n++;
        end
        check_eq("xreq_fwd_valid", 32'(d_req.a_valid), 32'd1);
        check_eq("xreq_fwd_addr", d_req.a_address, addr);
        @(posedge clk); #1;
        h_req.a_valid = 1'b0;
        $display("XBAR req addr=0x%08h src=0x%02h", addr, src);
    endtask

    task automatic xbar_rsp(input logic [7:0] src, input logic [31:0] data);
        d_rsp.d_valid  = 1'b1;
        d_rsp.d_opcode = OpAccessAckData;
        d_rsp.d_size   = 2'd2;
        d_rsp.d_source = src;
        d_rsp.d_data   = data;
        @(negedge clk);
        check_eq("xrsp_dvalid", 32'(h_rsp.d_valid), 32'd1);
        check_eq("xrsp_src", 32'(h_rsp.d_source), 32'(src));
        check_eq("xrsp_data", h_rsp.d_data, data);
        $display("XBAR rsp src=0x%02h d_data=0x%08h", h_rsp.d_source, h_rsp.d_data);
        @(posedge clk); #1;
        d_rsp.d_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        h_req         = '0;
        h_req.d_ready = 1'b1;
        d_rsp         = '0;
        d_rsp.a_ready = 1'b1;
        rst_n         = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_h_dvalid", 32'(h_rsp.d_valid), 32'd0);
        check_eq("rst_d_avalid", 32'(d_req.a_valid), 32'd0);
        check_eq("rst_d_dready", 32'(d_req.d_ready), 32'd1);
        check_eq("rst_rd_cnt", rd_cnt, 32'd0);
        check_eq("rst_wr_cnt", wr_cnt, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        sram_txn("put_full", OpPutFull, 32'h0010_0004, 2'd2, 4'hF, 32'hDEAD_BEEF, 32'h0, 1'b0);
        sram_txn("get_full", OpGet, 32'h0010_0004, 2'd2, 4'hF, 32'h0, 32'hDEAD_BEEF, 1'b0);
        sram_txn("put_base", OpPutFull, 32'h0010_0008, 2'd2, 4'hF, 32'h1122_3344, 32'h0, 1'b0);
        sram_txn("put_part", OpPutPartial, 32'h0010_0008, 2'd2, 4'b0010, 32'h0000_AA00,
                 32'h0, 1'b0);
        sram_txn("get_part", OpGet, 32'h0010_0008, 2'd2, 4'hF, 32'h0, 32'h1122_AA44, 1'b0);
        sram_txn("put_w0", OpPutFull, 32'h0010_0000, 2'd2, 4'hF, 32'hCAFE_F00D, 32'h0, 1'b0);
        sram_txn("get_oob", OpGet, 32'h0011_0000, 2'd2, 4'hF, 32'h0, 32'h0, 1'b1);
        sram_txn("put_oob", OpPutFull, 32'h0011_0000, 2'd2, 4'hF, 32'h5555_5555, 32'h0, 1'b1);
        sram_txn("get_w0", OpGet, 32'h0010_0000, 2'd2, 4'hF, 32'h0, 32'hCAFE_F00D, 1'b0);
        sram_txn("put_sz3", OpPutFull, 32'h0010_0008, 2'd3, 4'hF, 32'h7777_7777, 32'h0, 1'b1);
        sram_txn("get_after_sz3", OpGet, 32'h0010_0008, 2'd2, 4'hF, 32'h0, 32'h1122_AA44, 1'b0);
        sram_txn("get_misalign", OpGet, 32'h0010_0002, 2'd2, 4'hF, 32'h0, 32'h0, 1'b1);
        sram_txn("bad_opcode", 3'h2, 32'h0010_0004, 2'd2, 4'hF, 32'h0, 32'h0, 1'b1);
        sram_txn("get_still", OpGet, 32'h0010_0004, 2'd2, 4'hF, 32'h0, 32'hDEAD_BEEF, 1'b0);

        // Crossbar pass-through, with a_ready coming from the crossbar side.
        @(posedge clk); #1;
        d_rsp.a_ready   = 1'b0;
        h_req.a_valid   = 1'b1;
        h_req.a_opcode  = OpGet;
        h_req.a_size    = 2'd2;
        h_req.a_address = 32'h4000_0000;
        h_req.a_source  = 8'h5A;
        @(negedge clk);
        check_eq("xbar_fwd_valid", 32'(d_req.a_valid), 32'd1);
        check_eq("xbar_fwd_addr", d_req.a_address, 32'h4000_0000);
        check_eq("xbar_fwd_src", 32'(d_req.a_source), 32'h5A);
        check_eq("xbar_fwd_op", 32'(d_req.a_opcode), 32'(OpGet));
        check_eq("xbar_ready_low", 32'(h_rsp.a_ready), 32'd0);
        @(posedge clk); #1;
        d_rsp.a_ready = 1'b1;
        @(negedge clk);
        check_eq("xbar_ready_high", 32'(h_rsp.a_ready), 32'd1);
        @(posedge clk); #1;
        h_req.a_valid = 1'b0;
        $display("XBAR req addr=0x40000000 src=0x5a");
        xbar_rsp(8'h5A, 32'h1234_5678);

        // Two crossbar requests outstanding block both a third one and a SRAM request.
        xbar_req(32'h4000_0010, 8'h01);
        xbar_req(32'h4000_0020, 8'h02);
        h_req.a_valid   = 1'b1;
        h_req.a_address = 32'h4000_0030;
        h_req.a_source  = 8'h03;
        @(negedge clk);
        check_eq("xbar_max_block", 32'(d_req.a_valid), 32'd0);
        check_eq("xbar_max_ready", 32'(h_rsp.a_ready), 32'd0);
        @(posedge clk); #1;
        h_req.a_address = 32'h0010_0004;
        h_req.a_source  = 8'h04;
        d_rsp.d_valid   = 1'b1;
        d_rsp.d_opcode  = OpAccessAckData;
        d_rsp.d_source  = 8'h01;
        d_rsp.d_data    = 32'h0000_00A1;
        @(negedge clk);
        check_eq("sw_block0", 32'(h_rsp.a_ready), 32'd0);
        check_eq("sw_rsp0_src", 32'(h_rsp.d_source), 32'h01);
        @(posedge clk); #1;
        d_rsp.d_source = 8'h02;
        d_rsp.d_data   = 32'h0000_00A2;
        @(negedge clk);
        check_eq("sw_block1", 32'(h_rsp.a_ready), 32'd0);
        check_eq("sw_rsp1_src", 32'(h_rsp.d_source), 32'h02);
        check_eq("sw_rsp1_data", h_rsp.d_data, 32'h0000_00A2);
        @(posedge clk); #1;
        d_rsp.d_valid = 1'b0;
        @(negedge clk);
        check_eq("sw_accept", 32'(h_rsp.a_ready), 32'd1);
        @(posedge clk); #1;
        h_req.a_valid = 1'b0;
        exp_rd++;
        @(negedge clk);
        check_eq("sw_sram_dvalid", 32'(h_rsp.d_valid), 32'd1);
        check_eq("sw_sram_data", h_rsp.d_data, 32'hDEAD_BEEF);
        $display("SRAM sw_get addr=0x00100004 d_data=0x%08h", h_rsp.d_data);

        // Reset with two crossbar requests in flight.
        xbar_req(32'h4000_0040, 8'h08);
        xbar_req(32'h4000_0050, 8'h09);
        check_eq("pre_rst_rd_cnt", rd_cnt, StatsEn ? 32'(exp_rd) : 32'd0);
        check_eq("pre_rst_wr_cnt", wr_cnt, StatsEn ? 32'(exp_wr) : 32'd0);
        rst_n          = 1'b0;
        d_rsp.d_valid  = 1'b1;
        d_rsp.d_source = 8'h08;
        #1;
        check_eq("rst_mid_dvalid", 32'(h_rsp.d_valid), 32'd0);
        check_eq("rst_mid_dready", 32'(d_req.d_ready), 32'd1);
        check_eq("rst_mid_rd_cnt", rd_cnt, 32'd0);
        check_eq("rst_mid_wr_cnt", wr_cnt, 32'd0);
        exp_rd = 0;
        exp_wr = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("late_rsp_dvalid", 32'(h_rsp.d_valid), 32'd0);
        check_eq("late_rsp_dready", 32'(d_req.d_ready), 32'd1);
        $display("RESET late crossbar response discarded d_valid=%0d", h_rsp.d_valid);
        @(posedge clk); #1;
        d_rsp.d_valid = 1'b0;

        sram_txn("post_rst_get", OpGet, 32'h0010_0004, 2'd2, 4'hF, 32'h0, 32'hDEAD_BEEF, 1'b0);
        @(negedge clk);
        check_eq("post_rst_rd_cnt", rd_cnt, StatsEn ? 32'(exp_rd) : 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
